or_accum: RTL and testbench

//  Parametrised successor to the 2-input Or gate. Each accepted beat is WAYS words of WIDTH bits.
//  The words are bitwise-ORed together into one WIDTH-bit word.

---
 rtl/or_accum.sv | 123 ++++++++++++
 tb/tb_or_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/or_accum.sv
// or_accum: ORs WAYS words per beat and accumulates beats into a frame result.
// Optional macro OR_ACCUM_BEATCNT_EN adds the out_beats port.
module or_accum #(
    parameter int WIDTH     = 8,
    parameter int WAYS      = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WAYS*WIDTH-1:0]    in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_any,
    output logic                     out_forced
`ifdef OR_ACCUM_BEATCNT_EN
    ,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats
`endif
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_any;
    logic             r_out_forced;
`ifdef OR_ACCUM_BEATCNT_EN
    logic [CW-1:0]    r_out_beats;
`endif

    logic [WIDTH-1:0] w_beat;
    logic [WIDTH-1:0] w_merged;
    logic [CW-1:0]    w_cnt_next;
    logic             w_close;
    logic             w_accept;

    always_comb begin
        w_beat = '0;
        for (int unsigned k = 0; k < WAYS; k++) begin
            w_beat = w_beat | in_data[k*WIDTH +: WIDTH];
        end
    end

    // In IDLE the accumulator is ignored so a new frame starts from this beat alone.
    assign w_merged   = (r_state == S_IDLE) ? w_beat : (r_acc | w_beat);
    assign w_cnt_next = (r_state == S_IDLE) ? CW'(1) : (r_cnt + 1'b1);
    assign w_close    = in_last || (w_cnt_next == CW'(MAX_BEATS));
    assign w_accept   = in_valid && in_ready;

    assign in_ready   = (r_state != S_HOLD) && !reset;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_any    = r_out_any;
    assign out_forced = r_out_forced;
`ifdef OR_ACCUM_BEATCNT_EN
    assign out_beats  = r_out_beats;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_any    <= 1'b0;
            r_out_forced <= 1'b0;
`ifdef OR_ACCUM_BEATCNT_EN
            r_out_beats  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_merged;
                        r_cnt <= w_cnt_next;
                        if (w_close) begin
                            r_state      <= S_HOLD;
                            r_out_valid  <= 1'b1;
                            r_out_data   <= w_merged;
                            r_out_any    <= |w_merged;
                            r_out_forced <= !in_last;
`ifdef OR_ACCUM_BEATCNT_EN
                            r_out_beats  <= w_cnt_next;
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state      <= S_IDLE;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_out_valid  <= 1'b0;
                        r_out_data   <= '0;
                        r_out_any    <= 1'b0;
                        r_out_forced <= 1'b0;
`ifdef OR_ACCUM_BEATCNT_EN
                        r_out_beats  <= '0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_accum.sv
// Testbench for or_accum: directed steps plus random traffic against a scoreboard model.
module tb_or_accum;

    localparam int WIDTH     = 8;
    localparam int WAYS      = 2;
    localparam int MAX_BEATS = 4;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [WAYS*WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_any;
    logic                  out_forced;
`ifdef OR_ACCUM_BEATCNT_EN
    logic [CW-1:0]         out_beats;
`endif

    always #5 clk = ~clk;

    or_accum #(
        .WIDTH    (WIDTH),
        .WAYS     (WAYS),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_any   (out_any),
        .out_forced(out_forced)
`ifdef OR_ACCUM_BEATCNT_EN
        ,
        .out_beats (out_beats)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             forced;
        logic [CW-1:0]    beats;
    } exp_t;

    typedef enum {M_IDLE, M_ACCUM, M_HOLD} mst_t;

    exp_t             sb[$];
    mst_t             m_st;
    logic [WIDTH-1:0] m_acc;
    int               m_cnt;
    int               n_acc;
    int               n_total = 0;
    int               n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] or_words(input logic [WAYS*WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WAYS; k++) r = r | d[k*WIDTH +: WIDTH];
        return r;
    endfunction

    // Check outputs against the model's view of the current state, then advance model and clock.
    task automatic tick();
        exp_t e;
        logic [WIDTH-1:0] b;
        #1;
        check("in_ready", {31'b0, in_ready}, {31'b0, (!reset && m_st != M_HOLD)});
        check("out_valid", {31'b0, out_valid}, {31'b0, (m_st == M_HOLD)});
        if (m_st == M_HOLD) begin
            check("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                check("out_data", {24'b0, out_data}, {24'b0, sb[0].data});
                check("out_any", {31'b0, out_any}, {31'b0, |sb[0].data});
                check("out_forced", {31'b0, out_forced}, {31'b0, sb[0].forced});
`ifdef OR_ACCUM_BEATCNT_EN
                check("out_beats", {29'b0, out_beats}, {29'b0, sb[0].beats});
`endif
            end
        end else begin
            check("idle_data", {24'b0, out_data}, 32'h0);
            check("idle_any", {31'b0, out_any}, 32'h0);
            check("idle_forced", {31'b0, out_forced}, 32'h0);
`ifdef OR_ACCUM_BEATCNT_EN
            check("idle_beats", {29'b0, out_beats}, 32'h0);
`endif
        end

        if (reset) begin
            m_st  = M_IDLE;
            m_acc = '0;
            m_cnt = 0;
            sb.delete();
        end else if (m_st == M_HOLD) begin
            if (out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_st = M_IDLE;
            end
        end else if (in_valid) begin
            n_acc++;
            b = or_words(in_data);
            if (m_st == M_IDLE) begin
                m_acc = b;
                m_cnt = 1;
            end else begin
                m_acc = m_acc | b;
                m_cnt++;
            end
            if (in_last || m_cnt == MAX_BEATS) begin
                e.data   = m_acc;
                e.forced = !in_last;
                e.beats  = CW'(m_cnt);
                sb.push_back(e);
                m_st  = M_HOLD;
                m_acc = '0;
                m_cnt = 0;
            end else begin
                m_st = M_ACCUM;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WAYS*WIDTH-1:0] d, input logic last,
                         input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = rdy;
        tick();
    endtask

    initial begin
        int start_acc;
        int cyc;
        logic [1:0] ab;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        m_st = M_IDLE; m_acc = '0; m_cnt = 0; n_acc = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // T0: two beats in, then reset for two cycles; the partial frame must vanish
        drive(1'b1, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'h0200, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 16'h0040, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);

        // T1: truth table on bit 0 of each word, single-beat frames
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            drive(1'b1, {7'b0, ab[1], 7'b0, ab[0]}, 1'b1, 1'b1);
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
        end

        // T2: three-beat accumulate -> 8'h91
        drive(1'b1, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'h1000, 1'b0, 1'b1);
        drive(1'b1, 16'h8080, 1'b1, 1'b1);
        check("t2_valid", {31'b0, out_valid}, 32'h1);
        check("t2_data", {24'b0, out_data}, 32'h91);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);

        // T3: backpressure for five cycles in HOLD while the producer keeps offering
        drive(1'b1, 16'h2104, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1);
        check("t3_release_rdy", {31'b0, in_ready}, 32'h1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);

        // T4: six zero beats without in_last; cap closes after four, remainder starts clean
        for (int i = 0; i < 6; i++) drive(1'b1, 16'h0000, 1'b0, 1'b1);
        drive(1'b1, 16'h0008, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        // cap reached on a beat that also carries in_last: not forced
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0100, (i == 3), 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);

        // T5: random traffic, 1000 accepted beats within a bounded cycle budget
        start_acc = n_acc;
        cyc = 0;
        while ((n_acc - start_acc) < 1000 && cyc < 20000) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0));
            cyc++;
        end
        check("t5_beats_accepted", n_acc - start_acc, 1000);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
